sha2_w_expander: RTL
====================

SHA2_W_EXPANDER -- requirements
Module: sha2_w_expander

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning schedule word width; legal values are 32 (SHA-224/256) and 64 (SHA-384/512).
REQ-002 SHALL have parameter ROUNDS, default 64, meaning schedule words per block; legal values are 64 and 80.
REQ-003 SHALL have parameter WPC, default 1, meaning words emitted per output beat; legal values are 1, 2 and 4.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: block_in holds a valid block.
REQ-007 SHALL have port in_ready, output, 1 bit: the block expander accepts a block this cycle.
REQ-008 SHALL have port block_in, input, 16*WORD_W bits: a padded message block, W[0] in the MSBs and W[15] in the LSBs.
REQ-009 SHALL have port out_valid, output, 1 bit: w_out, w_idx and last are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the current beat.
REQ-011 SHALL have port w_out, output, WPC*WORD_W bits: W[t] in the MSBs through W[t+WPC-1] in the LSBs.
REQ-012 SHALL have port w_idx, output, 7 bits: t, the index of the first word in the beat.
REQ-013 SHALL have port last, output, 1 bit: the beat contains W[ROUNDS-1].

Function
REQ-014 SHALL fail elaboration for an illegal WORD_W, an illegal WPC, an illegal ROUNDS, or ROUNDS not divisible by WPC.
REQ-015 SHALL implement a two-state FSM, IDLE and EXPAND: the block is accepted on in_valid&in_ready; accepting moves IDLE->EXPAND; an accepted last beat with no new block moves EXPAND->IDLE.
REQ-016 SHALL drive in_ready = (state==IDLE) | (out_valid & out_ready & last), so back-to-back blocks incur no bubble.
REQ-017 SHALL register all outputs: a block accepted on edge N presents W[0..WPC-1] with w_idx=0 from edge N.
REQ-018 SHALL keep a 16-word sliding window that shifts by WPC words on every accepted beat (out_valid&out_ready).
REQ-019 SHALL take words for t<16 directly from the window.
REQ-020 SHALL compute words for t>=16 as W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] mod 2^WORD_W.
REQ-021 SHALL chain intra-beat dependencies combinationally when WPC>1.
REQ-022 SHALL use these sigma functions for WORD_W=32: s0=ROTR7^ROTR18^SHR3 and s1=ROTR17^ROTR19^SHR10.
REQ-023 SHALL use these sigma functions for WORD_W=64: s0=ROTR1^ROTR8^SHR7 and s1=ROTR19^ROTR61^SHR6.
REQ-024 SHALL hold w_out, w_idx and last stable while out_valid&!out_ready, for any number of cycles.
REQ-025 SHALL advance w_idx by WPC per accepted beat and emit exactly ROUNDS/WPC beats per block; last=1 only when w_idx=ROUNDS-WPC.
REQ-026 SHALL drop out_valid after an accepted last beat unless a new block is accepted in the same cycle, in which case the next beat carries the new block's W[0] with w_idx=0.
REQ-027 SHALL ignore in_valid while in_ready=0; block_in is not sampled.

Reset
REQ-028 SHALL, while RST=1, force the state to IDLE and drive in_ready=0, out_valid=0, last=0, w_out=0, w_idx=0, and a zero window.
REQ-029 SHALL, on RST asserted mid-block, abandon the block with no further beats; in_ready=1 on the first cycle after release.

Structure
REQ-030 SHALL place in shared package sha2_pkg: the FSM state enum, the rotate/shift constants for both word widths, and the sigma0/sigma1 functions parametrised by width.
REQ-031 SHALL implement one schedule-word computation as sub-module sha2_w_step, instantiated WPC times in a chain.

Verification
REQ-032 SHALL cover W32/R64/WPC1 with block "abc" (W0=0x61626380, W1..W14=0, W15=0x18) -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; last at w_idx=63.
REQ-033 SHALL cover W64/R80/WPC2 with W0=0x6162638000000000, W15=0x18, others 0 -> beat w_idx=16 gives {0x6162638000000000, 0x00030000000000C0}; 40 beats; last at w_idx=78.
REQ-034 SHALL cover an all-zero block, WPC4 -> every w_out=0, exactly 16 beats, last only on beat 15.
REQ-035 SHALL cover out_ready=0 for 3 cycles at w_idx=5 -> w_out/w_idx frozen; next accepted beat is w_idx=6; no word lost or repeated.
REQ-036 SHALL cover a second block presented with in_valid held high -> in_ready=1 in the cycle of the accepted last beat; the next cycle's beat is w_idx=0 of block 2.
REQ-037 SHALL cover RST pulsed at w_idx=20 -> out_valid=0 during reset; in_ready=1 after release; a new block restarts from w_idx=0.

Source files
------------

// File: rtl/sha2_pkg.sv
// ---------------------------------------------------------------------------
// sha2_pkg
// Shared definitions for the SHA-2 message schedule expander:
//   - sha2_state_t : FSM state encoding (IDLE / EXPAND)
//   - rotate/shift amounts of the small sigma functions for 32- and 64-bit words
//   - rotr, sigma0, sigma1 : width-parametrised helpers. Words travel in a
//     64-bit container; for width 32 only the low 32 bits are meaningful.
// ---------------------------------------------------------------------------
package sha2_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } sha2_state_t;

    // SHA-224/256
    localparam int S0_ROT_A_32 = 7;
    localparam int S0_ROT_B_32 = 18;
    localparam int S0_SHR_32   = 3;
    localparam int S1_ROT_A_32 = 17;
    localparam int S1_ROT_B_32 = 19;
    localparam int S1_SHR_32   = 10;

    // SHA-384/512
    localparam int S0_ROT_A_64 = 1;
    localparam int S0_ROT_B_64 = 8;
    localparam int S0_SHR_64   = 7;
    localparam int S1_ROT_A_64 = 19;
    localparam int S1_ROT_B_64 = 61;
    localparam int S1_SHR_64   = 6;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int width);
        logic [31:0] lo;
        if (width == 64) begin
            return (x >> n) | (x << (64 - n));
        end
        lo = x[31:0];
        return {32'd0, (lo >> n) | (lo << (32 - n))};
    endfunction

    function automatic logic [63:0] sigma0(input logic [63:0] x, input int width);
        if (width == 64) begin
            return rotr(x, S0_ROT_A_64, 64) ^ rotr(x, S0_ROT_B_64, 64) ^ (x >> S0_SHR_64);
        end
        return rotr(x, S0_ROT_A_32, 32) ^ rotr(x, S0_ROT_B_32, 32) ^ {32'd0, x[31:0] >> S0_SHR_32};
    endfunction

    function automatic logic [63:0] sigma1(input logic [63:0] x, input int width);
        if (width == 64) begin
            return rotr(x, S1_ROT_A_64, 64) ^ rotr(x, S1_ROT_B_64, 64) ^ (x >> S1_SHR_64);
        end
        return rotr(x, S1_ROT_A_32, 32) ^ rotr(x, S1_ROT_B_32, 32) ^ {32'd0, x[31:0] >> S1_SHR_32};
    endfunction

endpackage

// File: rtl/sha2_w_expander_if.sv
// ---------------------------------------------------------------------------
// sha2_w_expander_if
// Block-in / word-out handshake bundle of the schedule expander.
//   in_valid, in_ready, block_in   : message block input (W[0] in MSBs)
//   out_valid, out_ready           : output beat handshake
//   w_out, w_idx, last             : WPC words starting at W[w_idx]; last beat flag
// slave  : expander view.  master : producer/consumer (testbench) view.
// ---------------------------------------------------------------------------
interface sha2_w_expander_if #(
    parameter int WORD_W = 32,
    parameter int WPC    = 1
);
    logic                    in_valid;
    logic                    in_ready;
    logic [16*WORD_W-1:0]    block_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [WPC*WORD_W-1:0]   w_out;
    logic [6:0]              w_idx;
    logic                    last;

    modport slave (
        input  in_valid, block_in, out_ready,
        output in_ready, out_valid, w_out, w_idx, last
    );

    modport master (
        output in_valid, block_in, out_ready,
        input  in_ready, out_valid, w_out, w_idx, last
    );
endinterface

// File: rtl/sha2_w_step.sv
// ---------------------------------------------------------------------------
// sha2_w_step
// One schedule word: o_w_t = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
//   i_w_tm2, i_w_tm7, i_w_tm15, i_w_tm16 : predecessor words
//   o_w_t                                : new word, modulo 2^WORD_W
// ---------------------------------------------------------------------------
module sha2_w_step #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] i_w_tm2,
    input  logic [WORD_W-1:0] i_w_tm7,
    input  logic [WORD_W-1:0] i_w_tm15,
    input  logic [WORD_W-1:0] i_w_tm16,
    output logic [WORD_W-1:0] o_w_t
);
    import sha2_pkg::*;

    logic [WORD_W-1:0] w_s0;
    logic [WORD_W-1:0] w_s1;

    assign w_s1  = WORD_W'(sigma1(64'(i_w_tm2), WORD_W));
    assign w_s0  = WORD_W'(sigma0(64'(i_w_tm15), WORD_W));
    assign o_w_t = w_s1 + i_w_tm7 + w_s0 + i_w_tm16;
endmodule

// File: rtl/sha2_w_expander.sv
// ---------------------------------------------------------------------------
// sha2_w_expander
// SHA-2 message schedule expander. Accepts one 16-word block and streams
// W[0..ROUNDS-1], WPC words per beat.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : sha2_w_expander_if.slave (block input and word output handshakes)
// The 16-word window always holds W[t..t+15] for the beat currently shown,
// so the output words are simply the window head and each accepted beat
// shifts in WPC freshly computed words.
// ---------------------------------------------------------------------------
module sha2_w_expander #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int WPC    = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    sha2_w_expander_if.slave        bus
);
    import sha2_pkg::*;

    generate
        if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
            $error("sha2_w_expander: WORD_W must be 32 or 64");
        end
        if (!(ROUNDS == 64 || ROUNDS == 80)) begin : g_bad_rounds
            $error("sha2_w_expander: ROUNDS must be 64 or 80");
        end
        if (!(WPC == 1 || WPC == 2 || WPC == 4)) begin : g_bad_wpc
            $error("sha2_w_expander: WPC must be 1, 2 or 4");
        end
        if ((ROUNDS % WPC) != 0) begin : g_bad_div
            $error("sha2_w_expander: ROUNDS must be divisible by WPC");
        end
    endgenerate

    sha2_state_t        r_state;
    sha2_state_t        w_state_next;
    logic [WORD_W-1:0]  r_window [16];
    logic [WORD_W-1:0]  w_win_shift [16];
    logic [6:0]         r_w_idx;
    logic               r_last;
    logic               w_out_valid;
    logic               w_beat_acc;
    logic               w_in_ready;
    logic               w_blk_acc;

    assign w_out_valid = (r_state == ST_EXPAND);
    assign w_beat_acc  = w_out_valid & bus.out_ready;
    // Accepting the final beat frees the expander in the same cycle, so a
    // waiting block follows without a bubble. Held low throughout reset.
    assign w_in_ready  = ~RST & ((r_state == ST_IDLE) | (w_beat_acc & r_last));
    assign w_blk_acc   = bus.in_valid & w_in_ready;

    // WPC chained word computations; step gi produces W[t+16+gi]. Its t-2
    // operand comes from the window for the first two steps and from the
    // step two positions earlier otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < WPC; gi++) begin : g_step
            logic [WORD_W-1:0] w_tm2;
            logic [WORD_W-1:0] w_word;
            if (gi >= 2) begin : g_chain
                assign w_tm2 = g_step[gi-2].w_word;
            end else begin : g_win
                assign w_tm2 = r_window[14+gi];
            end
            sha2_w_step #(.WORD_W(WORD_W)) u_step (
                .i_w_tm2  (w_tm2),
                .i_w_tm7  (r_window[9+gi]),
                .i_w_tm15 (r_window[1+gi]),
                .i_w_tm16 (r_window[gi]),
                .o_w_t    (w_word)
            );
        end

        for (gi = 0; gi < 16; gi++) begin : g_shift
            if (gi + WPC < 16) begin : g_keep
                assign w_win_shift[gi] = r_window[gi+WPC];
            end else begin : g_new
                assign w_win_shift[gi] = g_step[gi+WPC-16].w_word;
            end
        end

        for (gi = 0; gi < WPC; gi++) begin : g_out
            assign bus.w_out[(WPC-1-gi)*WORD_W +: WORD_W] = r_window[gi];
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_blk_acc) w_state_next = ST_EXPAND;
            end
            ST_EXPAND: begin
                if (w_beat_acc && r_last && !w_blk_acc) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 16; k++) r_window[k] <= '0;
            r_w_idx <= '0;
            r_last  <= 1'b0;
        end else if (w_blk_acc) begin
            for (int k = 0; k < 16; k++) r_window[k] <= bus.block_in[(15-k)*WORD_W +: WORD_W];
            r_w_idx <= '0;
            r_last  <= 1'b0;
        end else if (w_beat_acc) begin
            for (int k = 0; k < 16; k++) r_window[k] <= w_win_shift[k];
            r_w_idx <= r_w_idx + 7'(WPC);
            r_last  <= (r_w_idx + 7'(WPC) == 7'(ROUNDS - WPC));
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.w_idx     = r_w_idx;
    assign bus.last      = r_last;
endmodule
